// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter and its FIFO.
// The BREAK state exists only when UART_TX_BREAK_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
    , ST_BREAK = 3'd5
`endif
  } uart_state_t;

  localparam logic [2:0] PARITY_NONE  = 3'd0;
  localparam logic [2:0] PARITY_EVEN  = 3'd1;
  localparam logic [2:0] PARITY_ODD   = 3'd2;
  localparam logic [2:0] PARITY_MARK  = 3'd3;
  localparam logic [2:0] PARITY_SPACE = 3'd4;

  localparam int unsigned BREAK_MULT = 16;

  // Codes 5-7 are reserved and behave like PARITY_NONE.
  function automatic logic parity_enabled(input logic [2:0] mode);
    return (mode == PARITY_EVEN) || (mode == PARITY_ODD) ||
           (mode == PARITY_MARK) || (mode == PARITY_SPACE);
  endfunction

  function automatic logic parity_bit(input logic [2:0] mode, input logic data_xor);
    logic bit_v;
    case (mode)
      PARITY_EVEN:  bit_v = data_xor;
      PARITY_ODD:   bit_v = ~data_xor;
      PARITY_MARK:  bit_v = 1'b1;
      PARITY_SPACE: bit_v = 1'b0;
      default:      bit_v = 1'b1;
    endcase
    return bit_v;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with push/pop/flush and a registered occupancy level.
// Written to be shared by the TX path and a future buffered RX.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int FIFO_DEPTH = 8,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1),
  localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [LVL_W-1:0]      o_level,
  output logic [LVL_W-1:0]      o_level_nxt,
  output logic                  o_full,
  output logic                  o_empty
);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_do_push;
  logic                  w_do_pop;

  // Full/empty come from the registered level so a same-edge pop never frees a slot early.
  assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty   = (r_level == {LVL_W{1'b0}});
  assign w_do_push = i_push && !w_full && !i_flush;
  assign w_do_pop  = i_pop && !w_empty && !i_flush;

  // Next occupancy, exported so the owner can register flags that depend on it.
  always_comb begin
    o_level_nxt = r_level;
    if (i_flush) begin
      o_level_nxt = {LVL_W{1'b0}};
    end else if (w_do_push && !w_do_pop) begin
      o_level_nxt = r_level + LVL_W'(1);
    end else if (w_do_pop && !w_do_push) begin
      o_level_nxt = r_level - LVL_W'(1);
    end else begin
      o_level_nxt = r_level;
    end
  end

  // Pointers and level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_level  <= {LVL_W{1'b0}};
    end else if (i_flush) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_level  <= {LVL_W{1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= o_level_nxt;
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter with per-frame latched divisor/format.
// Defining UART_TX_BREAK_EN adds break_req/break_len and the BREAK state.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int FIFO_DEPTH = 8,
  parameter  int DIV_WIDTH  = 16,
  localparam int BC_W       = $clog2(DATA_WIDTH + 1),
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic [2:0]            parity_mode,
  input  logic                  msb_first,
  input  logic [BC_W-1:0]       bit_count,
  input  logic [3:0]            stop_count,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  flush,
`ifdef UART_TX_BREAK_EN
  input  logic                  break_req,
  input  logic [3:0]            break_len,
`endif
  output logic                  tx,
  output logic                  busy,
  output logic                  idle,
  output logic                  strobe_started,
  output logic [LVL_W-1:0]      fifo_level
);

  localparam int BRK_W = 8;

  uart_state_t           r_state, w_state_nxt;
  logic [DIV_WIDTH-1:0]  r_cnt, w_cnt_nxt;
  logic [DIV_WIDTH-1:0]  r_div, w_div_nxt;
  logic [2:0]            r_par, w_par_nxt;
  logic                  r_msb, w_msb_nxt;
  logic [BC_W-1:0]       r_bits, w_bits_nxt;
  logic [3:0]            r_stops, w_stops_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic                  r_xor, w_xor_nxt;
  logic                  r_tx, w_tx_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_strobe, w_strobe_nxt;
  logic                  r_idle, w_idle_nxt;
`ifdef UART_TX_BREAK_EN
  logic [BRK_W-1:0]      r_brk, w_brk_nxt;
`endif

  logic                  w_pop;
  logic                  w_launch;
  logic                  w_push;
  logic [DATA_WIDTH-1:0] w_fifo_data;
  logic [LVL_W-1:0]      w_level;
  logic [LVL_W-1:0]      w_level_nxt;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [DIV_WIDTH-1:0]  w_div_eff;
  logic [BC_W-1:0]       w_nbits_eff;
  logic [3:0]            w_nstop_eff;
  logic [BC_W-1:0]       w_align;
  logic                  w_bit_end;
  logic [DIV_WIDTH-1:0]  w_reload;
  logic                  w_cur_bit;
  logic [DATA_WIDTH-1:0] w_shifted;

  assign w_push = s_valid && !w_fifo_full;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_data      (s_data),
    .i_pop       (w_pop),
    .i_flush     (flush),
    .o_data      (w_fifo_data),
    .o_level     (w_level),
    .o_level_nxt (w_level_nxt),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  assign w_div_eff   = (div == {DIV_WIDTH{1'b0}}) ? DIV_WIDTH'(1) : div;
  assign w_nbits_eff = ((bit_count == {BC_W{1'b0}}) || (bit_count > BC_W'(DATA_WIDTH)))
                       ? BC_W'(DATA_WIDTH) : bit_count;
  assign w_nstop_eff = (stop_count == 4'd0) ? 4'd1 : stop_count;
  // MSB-first words are pre-aligned so the first bit sits at the top of the shifter.
  assign w_align     = BC_W'(DATA_WIDTH) - w_nbits_eff;
  assign w_bit_end   = (r_cnt == {DIV_WIDTH{1'b0}});
  assign w_reload    = r_div - DIV_WIDTH'(1);
  assign w_cur_bit   = r_msb ? r_shift[DATA_WIDTH-1] : r_shift[0];
  assign w_shifted   = r_msb ? (r_shift << 1) : (r_shift >> 1);

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_div_nxt    = r_div;
    w_par_nxt    = r_par;
    w_msb_nxt    = r_msb;
    w_bits_nxt   = r_bits;
    w_stops_nxt  = r_stops;
    w_shift_nxt  = r_shift;
    w_xor_nxt    = r_xor;
    w_tx_nxt     = r_tx;
    w_busy_nxt   = r_busy;
    w_strobe_nxt = 1'b0;
    w_pop        = 1'b0;
    w_launch     = 1'b0;
`ifdef UART_TX_BREAK_EN
    w_brk_nxt    = r_brk;
`endif
    case (r_state)
      ST_IDLE: w_launch = 1'b1;
      ST_START: begin
        if (!w_bit_end) begin
          w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
        end else begin
          w_state_nxt = ST_DATA;
          w_tx_nxt    = w_cur_bit;
          w_xor_nxt   = w_cur_bit;
          w_shift_nxt = w_shifted;
          w_bits_nxt  = r_bits - BC_W'(1);
          w_cnt_nxt   = w_reload;
        end
      end
      ST_DATA: begin
        if (!w_bit_end) begin
          w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
        end else if (r_bits != {BC_W{1'b0}}) begin
          w_tx_nxt    = w_cur_bit;
          w_xor_nxt   = r_xor ^ w_cur_bit;
          w_shift_nxt = w_shifted;
          w_bits_nxt  = r_bits - BC_W'(1);
          w_cnt_nxt   = w_reload;
        end else if (parity_enabled(r_par)) begin
          w_state_nxt = ST_PARITY;
          w_tx_nxt    = parity_bit(r_par, r_xor);
          w_cnt_nxt   = w_reload;
        end else begin
          w_state_nxt = ST_STOP;
          w_tx_nxt    = 1'b1;
          w_cnt_nxt   = w_reload;
        end
      end
      ST_PARITY: begin
        if (!w_bit_end) begin
          w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
        end else begin
          w_state_nxt = ST_STOP;
          w_tx_nxt    = 1'b1;
          w_cnt_nxt   = w_reload;
        end
      end
      ST_STOP: begin
        if (!w_bit_end) begin
          w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
        end else if (r_stops != 4'd0) begin
          w_stops_nxt = r_stops - 4'd1;
          w_cnt_nxt   = w_reload;
        end else begin
          w_launch = 1'b1;
        end
      end
`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        if (!w_bit_end) begin
          w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
        end else if (r_brk != {BRK_W{1'b0}}) begin
          w_brk_nxt = r_brk - BRK_W'(1);
          w_cnt_nxt = w_reload;
        end else begin
          w_state_nxt = ST_STOP;
          w_tx_nxt    = 1'b1;
          w_stops_nxt = 4'd0;
          w_cnt_nxt   = w_reload;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase

    // Decision point shared by IDLE and the last stop bit; flush blocks a pop.
    if (w_launch) begin
`ifdef UART_TX_BREAK_EN
      if (break_req) begin
        w_state_nxt = ST_BREAK;
        w_tx_nxt    = 1'b0;
        w_busy_nxt  = 1'b1;
        w_div_nxt   = w_div_eff;
        w_cnt_nxt   = w_div_eff - DIV_WIDTH'(1);
        w_brk_nxt   = BRK_W'((int'(break_len) + 1) * BREAK_MULT - 1);
      end else
`endif
      if (!w_fifo_empty && !flush) begin
        w_pop        = 1'b1;
        w_state_nxt  = ST_START;
        w_tx_nxt     = 1'b0;
        w_busy_nxt   = 1'b1;
        w_strobe_nxt = 1'b1;
        w_div_nxt    = w_div_eff;
        w_cnt_nxt    = w_div_eff - DIV_WIDTH'(1);
        w_par_nxt    = parity_mode;
        w_msb_nxt    = msb_first;
        w_bits_nxt   = w_nbits_eff;
        w_stops_nxt  = w_nstop_eff - 4'd1;
        w_shift_nxt  = msb_first ? (w_fifo_data << w_align) : w_fifo_data;
      end else begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    end else begin
      w_pop = 1'b0;
    end
  end

  assign w_idle_nxt = !w_busy_nxt && (w_level_nxt == {LVL_W{1'b0}});

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= {DIV_WIDTH{1'b0}};
      r_div    <= DIV_WIDTH'(1);
      r_par    <= PARITY_NONE;
      r_msb    <= 1'b0;
      r_bits   <= {BC_W{1'b0}};
      r_stops  <= 4'd0;
      r_shift  <= {DATA_WIDTH{1'b0}};
      r_xor    <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_strobe <= 1'b0;
      r_idle   <= 1'b1;
`ifdef UART_TX_BREAK_EN
      r_brk    <= {BRK_W{1'b0}};
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_div    <= w_div_nxt;
      r_par    <= w_par_nxt;
      r_msb    <= w_msb_nxt;
      r_bits   <= w_bits_nxt;
      r_stops  <= w_stops_nxt;
      r_shift  <= w_shift_nxt;
      r_xor    <= w_xor_nxt;
      r_tx     <= w_tx_nxt;
      r_busy   <= w_busy_nxt;
      r_strobe <= w_strobe_nxt;
      r_idle   <= w_idle_nxt;
`ifdef UART_TX_BREAK_EN
      r_brk    <= w_brk_nxt;
`endif
    end
  end

  assign s_ready        = !w_fifo_full;
  assign tx             = r_tx;
  assign busy           = r_busy;
  assign idle           = r_idle;
  assign strobe_started = r_strobe;
  assign fifo_level     = w_level;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: a line decoder pops expected words
// from a scoreboard and compares each decoded frame against a reference frame.
`timescale 1ns/1ps
module tb_uart_tx_buffered;

  localparam int DW   = 16;
  localparam int FD   = 8;
  localparam int DIVW = 16;
  localparam int BCW  = $clog2(DW + 1);
  localparam int LVLW = $clog2(FD + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [DIVW-1:0] div;
  logic [2:0]      parity_mode;
  logic            msb_first;
  logic [BCW-1:0]  bit_count;
  logic [3:0]      stop_count;
  logic [DW-1:0]   s_data;
  logic            s_valid;
  logic            s_ready;
  logic            flush;
  logic            tx, busy, idle, strobe_started;
  logic [LVLW-1:0] fifo_level;
`ifdef UART_TX_BREAK_EN
  logic            break_req;
  logic [3:0]      break_len;
`endif

  always #5 clk = ~clk;

  uart_tx_buffered #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .DIV_WIDTH(DIVW)) dut (
    .clk(clk), .rst(rst), .div(div), .parity_mode(parity_mode), .msb_first(msb_first),
    .bit_count(bit_count), .stop_count(stop_count), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .flush(flush),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req), .break_len(break_len),
`endif
    .tx(tx), .busy(busy), .idle(idle), .strobe_started(strobe_started), .fifo_level(fifo_level)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] sb[$];
  bit  mon_en = 1'b0;
  int  cyc = 0;
  int  n_frames = 0;
  int  frame_start[$];
  int  strobe_cnt = 0;
  int  lvl_max = 0;
  int  rdy_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (strobe_started === 1'b1) strobe_cnt <= strobe_cnt + 1;
    if (int'(fifo_level) > lvl_max) lvl_max <= int'(fifo_level);
    if (!rst && (s_ready !== (int'(fifo_level) < FD))) rdy_err <= rdy_err + 1;
  end

  // Reference line image for one word under the current configuration.
  function automatic int build_frame(input logic [DW-1:0] w, output logic [63:0] bits);
    int nb, ns, idx;
    logic x, b;
    nb = ((bit_count == 0) || (int'(bit_count) > DW)) ? DW : int'(bit_count);
    ns = (stop_count == 4'd0) ? 1 : int'(stop_count);
    bits = 64'd0;
    x = 1'b0;
    idx = 1;
    for (int i = 0; i < nb; i++) begin
      b = msb_first ? w[nb-1-i] : w[i];
      bits[idx] = b;
      x = x ^ b;
      idx++;
    end
    case (parity_mode)
      3'd1: begin bits[idx] = x;    idx++; end
      3'd2: begin bits[idx] = ~x;   idx++; end
      3'd3: begin bits[idx] = 1'b1; idx++; end
      3'd4: begin bits[idx] = 1'b0; idx++; end
      default: ;
    endcase
    for (int i = 0; i < ns; i++) begin
      bits[idx] = 1'b1;
      idx++;
    end
    return idx;
  endfunction

  // Line decoder: a low sample on an idle line starts a frame.
  initial begin : monitor
    logic [63:0]   exp_bits, obs_bits;
    logic [DW-1:0] w;
    int n, dv, unstable;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && tx === 1'b0) begin
        n_frames++;
        frame_start.push_back(cyc);
        dv = (div == 0) ? 1 : int'(div);
        check_eq("sb_has_entry", 64'(sb.size() > 0), 64'd1);
        w = (sb.size() > 0) ? sb.pop_front() : {DW{1'b0}};
        n = build_frame(w, exp_bits);
        obs_bits = 64'd0;
        unstable = 0;
        for (int k = 0; k < n; k++) begin
          for (int s = 0; s < dv; s++) begin
            if (k != 0 || s != 0) @(negedge clk);
            if (s == 0) obs_bits[k] = tx;
            else if (tx !== obs_bits[k]) unstable++;
          end
        end
        check_eq("frame_bits", obs_bits, exp_bits);
        check_eq("frame_bit_width", 64'(unstable), 64'd0);
      end
    end
  end

  task automatic push_word(input logic [DW-1:0] w, input bit expect_tx);
    int t;
    t = 0;
    s_data  = w;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("push_ready", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
    if (expect_tx) sb.push_back(w);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    while (idle !== 1'b1 && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
    end
    check_eq("idle_reached", 64'(idle), 64'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int c, s0, fs0, nf0, lo, hi;
    div = 16'd4; parity_mode = 3'd0; msb_first = 1'b0; bit_count = 5'd8; stop_count = 4'd1;
    s_data = {DW{1'b0}}; s_valid = 1'b0; flush = 1'b0;
`ifdef UART_TX_BREAK_EN
    break_req = 1'b0; break_len = 4'd0;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_tx", 64'(tx), 64'd1);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_idle", 64'(idle), 64'd1);
    check_eq("rst_strobe", 64'(strobe_started), 64'd0);
    check_eq("rst_ready", 64'(s_ready), 64'd1);
    check_eq("rst_level", 64'(fifo_level), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // div=4, 8N1, LSB first, 0xA5
    mon_en = 1'b1;
    s0 = strobe_cnt;
    push_word(16'h00A5, 1'b1);
    check_eq("t1_tx_at_E", 64'(tx), 64'd1);
    check_eq("t1_level_at_E", 64'(fifo_level), 64'd1);
    check_eq("t1_idle_at_E", 64'(idle), 64'd0);
    @(posedge clk); #1;
    check_eq("t1_tx_at_E1", 64'(tx), 64'd0);
    check_eq("t1_busy_at_E1", 64'(busy), 64'd1);
    check_eq("t1_strobe_at_E1", 64'(strobe_started), 64'd1);
    check_eq("t1_level_at_E1", 64'(fifo_level), 64'd0);
    wait_idle(200, c);
    check_eq("t1_strobe_count", 64'(strobe_cnt - s0), 64'd1);
    repeat (3) @(posedge clk); #1;

    // div=3, 7 bits, odd parity, MSB first, 2 stops, back-to-back frames
    div = 16'd3; bit_count = 5'd7; parity_mode = 3'd2; msb_first = 1'b1; stop_count = 4'd2;
    fs0 = frame_start.size();
    push_word(16'h0041, 1'b1);
    push_word(16'h0042, 1'b1);
    check_eq("t2_level", 64'(fifo_level), 64'd1);
    check_eq("t2_busy", 64'(busy), 64'd1);
    wait_idle(500, c);
    check_eq("t2_idle_after_both", 64'(c), 64'd66);
    check_eq("t2_frame_count", 64'(frame_start.size() - fs0), 64'd2);
    if (frame_start.size() >= fs0 + 2)
      check_eq("t2_contiguous", 64'(frame_start[fs0+1] - frame_start[fs0]), 64'd33);
    repeat (3) @(posedge clk); #1;

    // div=100, 8N1, ten words into an 8-deep FIFO
    div = 16'd100; bit_count = 5'd8; parity_mode = 3'd0; msb_first = 1'b0; stop_count = 4'd1;
    for (int i = 0; i < 9; i++) push_word(DW'($urandom_range(0, 65535)), 1'b1);
    check_eq("t3_level_full", 64'(fifo_level), 64'd8);
    check_eq("t3_ready_low", 64'(s_ready), 64'd0);
    push_word(DW'($urandom_range(0, 65535)), 1'b1);
    wait_idle(12000, c);
    check_eq("t3_level_peak", 64'(lvl_max), 64'd8);
    repeat (3) @(posedge clk); #1;

    // flush mid-frame with a same-edge push
    div = 16'd4;
    nf0 = n_frames;
    push_word(16'h0011, 1'b1);
    push_word(16'h0022, 1'b0);
    push_word(16'h0033, 1'b0);
    push_word(16'h0044, 1'b0);
    check_eq("t4_level_before", 64'(fifo_level), 64'd3);
    repeat (4) @(posedge clk); #1;
    flush = 1'b1; s_valid = 1'b1; s_data = 16'h0077;
    @(posedge clk); #1;
    flush = 1'b0; s_valid = 1'b0;
    check_eq("t4_level_after_flush", 64'(fifo_level), 64'd0);
    check_eq("t4_busy_after_flush", 64'(busy), 64'd1);
    wait_idle(200, c);
    repeat (60) @(posedge clk); #1;
    check_eq("t4_frames", 64'(n_frames - nf0), 64'd1);
    check_eq("t4_level_end", 64'(fifo_level), 64'd0);

    // async reset in the middle of a data bit
    mon_en = 1'b0;
    push_word(16'h0033, 1'b0);
    repeat (8) @(posedge clk);
    #3;
    check_eq("t5_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("t5_tx_async", 64'(tx), 64'd1);
    check_eq("t5_busy_async", 64'(busy), 64'd0);
    check_eq("t5_level_async", 64'(fifo_level), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    mon_en = 1'b1;
    push_word(16'h005A, 1'b1);
    wait_idle(200, c);
    repeat (3) @(posedge clk); #1;

`ifdef UART_TX_BREAK_EN
    // break in IDLE with one word queued
    div = 16'd2;
    mon_en = 1'b0;
    s0 = strobe_cnt;
    break_len = 4'd0;
    push_word(16'h00C3, 1'b0);
    break_req = 1'b1;
    @(posedge clk); #1;
    break_req = 1'b0;
    check_eq("t6_busy_break", 64'(busy), 64'd1);
    check_eq("t6_strobe_break", 64'(strobe_started), 64'd0);
    lo = 0;
    while (tx === 1'b0 && lo < 100) begin
      lo++;
      @(posedge clk); #1;
    end
    check_eq("t6_low_clocks", 64'(lo), 64'd32);
    mon_en = 1'b1;
    sb.push_back(16'h00C3);
    hi = 0;
    while (tx === 1'b1 && hi < 100) begin
      hi++;
      @(posedge clk); #1;
    end
    check_eq("t6_high_clocks", 64'(hi), 64'd2);
    check_eq("t6_frame_strobe", 64'(strobe_started), 64'd1);
    check_eq("t6_no_break_strobe", 64'(strobe_cnt - s0), 64'd0);
    wait_idle(200, c);
    repeat (3) @(posedge clk); #1;
`endif

    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    check_eq("ready_tracks_level", 64'(rdy_err), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
